seg_scan_driver: RTL

Multiplexed N-digit 7-segment display driver with registered outputs. It latches a packed hex value and scans one digit per slot, driving active-low anodes and active-low segments. It decodes 0-F, inserts an anti-ghosting guard interval at the start of each slot, and updates the displayed value only at frame boundaries so a frame never shows a mix of old and new digits. It sits between the recorder's status/counter logic and the board's common-anode display, replacing per-digit combinational decoders.

---
 rtl/seg_scan_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment scan driver with frame-synchronous update.
// Optional: define SEG_LEAD_ZERO_BLANK_EN to compile in leading-zero suppression.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [VW-1:0]     pend;
    logic              pend_v;
    logic [VW-1:0]     disp;

    logic              cnt_last;
    logic              boundary;
    logic              guard_on;
    logic              sup_cur;
    logic              lit;
    logic [3:0]        nib;

    logic [6:0]        seg_d;
    logic              dp_d;
    logic [DIGITS-1:0] an_d;

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign cnt_last = (cnt == CNT_LAST);
    assign boundary = cnt_last && (idx == IDX_LAST);
    assign guard_on = (cnt < GUARD_C);
    assign nib      = disp[{idx, 2'b00} +: 4];

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0] sup;

    // A digit is dark while it and every digit to its left are zero
    always_comb begin
        logic nz;
        nz  = 1'b0;
        sup = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            nz     = nz | (disp[4*i +: 4] != 4'h0);
            sup[i] = ~nz;
        end
    end

    assign sup_cur = sup[idx];
`else
    assign sup_cur = 1'b0;
`endif

    assign lit = ~blank & ~guard_on & ~sup_cur;

    // Slot timing: cnt runs every cycle, idx steps at each slot end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending value is only promoted to the display at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            pend_v <= 1'b0;
            disp   <= '0;
        end else if (boundary) begin
            if (load) begin
                disp   <= value;
                pend_v <= 1'b0;
            end else if (pend_v) begin
                disp   <= pend;
                pend_v <= 1'b0;
            end
        end else if (load) begin
            pend   <= value;
            pend_v <= 1'b1;
        end
    end

    // Next-cycle anode, segment and decimal point for the current slot
    always_comb begin
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx] = 1'b0;
            seg_d     = decode(nib);
            dp_d      = ~dp_in[idx];
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= 7'b1111111;
            dp    <= 1'b1;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            seg   <= seg_d;
            dp    <= dp_d;
            an    <= an_d;
            frame <= boundary;
        end
    end

endmodule
